// File: rtl/pipe_pkg.sv
// Shared opcode constants, injected NOP word and sequencer state encoding
// for the four-stage IR1..IR4 pipeline.
package pipe_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_NOP   = 4'b1010;
    localparam logic [3:0] OP_BPZ   = 4'b1101;

    // Shift and ori are identified by their low three opcode bits only.
    localparam logic [2:0] SHIFT_LO = 3'b011;
    localparam logic [2:0] ORI_LO   = 3'b111;

    localparam logic [7:0] NOP_IR = 8'b00001010;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/instr_reg_use.sv
// Decodes one instruction word into its register read/write usage and
// the memory/stop class flags needed for hazard detection.
module instr_reg_use
    import pipe_pkg::*;
(
    input  logic [7:0] ir,
    output logic       reads_ra,
    output logic       reads_rb,
    output logic       reads_k1,
    output logic       writes_ra,
    output logic       is_load,
    output logic       is_mem,
    output logic       is_stop
);

    logic [3:0] op;
    logic       unused_fields;

    assign op            = ir[3:0];
    assign unused_fields = ^ir[7:4];

    always_comb begin
        reads_ra  = 1'b0;
        reads_rb  = 1'b0;
        reads_k1  = 1'b0;
        writes_ra = 1'b0;
        is_load   = 1'b0;
        is_mem    = 1'b0;
        is_stop   = 1'b0;
        case (op)
            OP_LOAD: begin
                reads_rb  = 1'b1;
                writes_ra = 1'b1;
                is_load   = 1'b1;
                is_mem    = 1'b1;
            end
            OP_STORE: begin
                reads_ra = 1'b1;
                reads_rb = 1'b1;
                is_mem   = 1'b1;
            end
            OP_ADD, OP_SUB, OP_NAND: begin
                reads_ra  = 1'b1;
                reads_rb  = 1'b1;
                writes_ra = 1'b1;
            end
            OP_STOP: is_stop = 1'b1;
            OP_BZ, OP_BNZ, OP_BPZ, OP_NOP: ;
            default: begin
                if (op[2:0] == SHIFT_LO) begin
                    reads_ra  = 1'b1;
                    writes_ra = 1'b1;
                end else if (op[2:0] == ORI_LO) begin
                    reads_k1 = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencer: stage load enables, PC hold, bubble/flush injection,
// memory-wait freeze, stop/halt, plus saturating stall and flush counters.
module hazard_sequencer
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       IR1Out,
    input  logic [7:0]       IR2Out,
    input  logic [7:0]       IR3Out,
    input  logic             BrTaken,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             IR1Load,
    output logic             IR2Load,
    output logic             IR3Load,
    output logic             IR4Load,
    output logic             IR1Flush,
    output logic             IR2Flush,
    output logic             Halted,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    // state | meaning
    // RUN   | normal issue; stop, branch and load-use evaluated here
    // STALL | single bubble cycle after a load-use hazard
    // HALT  | stop reached execute; IR3/IR4 drain, frozen until reset
    seq_state_t state, next_state;

    logic ir1_reads_ra, ir1_reads_rb, ir1_reads_k1, ir1_writes_ra;
    logic ir1_is_load, ir1_is_mem, ir1_is_stop;
    logic ir2_reads_ra, ir2_reads_rb, ir2_reads_k1, ir2_writes_ra;
    logic ir2_is_load, ir2_is_mem, ir2_is_stop;
    logic ir3_reads_ra, ir3_reads_rb, ir3_reads_k1, ir3_writes_ra;
    logic ir3_is_load, ir3_is_mem, ir3_is_stop;
    logic unused_use;

    logic       freeze, load_use;
    logic       inc_stall, inc_flush;
    logic [1:0] load_dst;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    instr_reg_use u_use_ir1 (
        .ir(IR1Out), .reads_ra(ir1_reads_ra), .reads_rb(ir1_reads_rb),
        .reads_k1(ir1_reads_k1), .writes_ra(ir1_writes_ra), .is_load(ir1_is_load),
        .is_mem(ir1_is_mem), .is_stop(ir1_is_stop)
    );

    instr_reg_use u_use_ir2 (
        .ir(IR2Out), .reads_ra(ir2_reads_ra), .reads_rb(ir2_reads_rb),
        .reads_k1(ir2_reads_k1), .writes_ra(ir2_writes_ra), .is_load(ir2_is_load),
        .is_mem(ir2_is_mem), .is_stop(ir2_is_stop)
    );

    instr_reg_use u_use_ir3 (
        .ir(IR3Out), .reads_ra(ir3_reads_ra), .reads_rb(ir3_reads_rb),
        .reads_k1(ir3_reads_k1), .writes_ra(ir3_writes_ra), .is_load(ir3_is_load),
        .is_mem(ir3_is_mem), .is_stop(ir3_is_stop)
    );

    assign unused_use = ^{ir1_writes_ra, ir1_is_load, ir1_is_mem, ir1_is_stop,
                          ir2_reads_ra, ir2_reads_rb, ir2_reads_k1, ir2_writes_ra, ir2_is_mem,
                          ir3_reads_ra, ir3_reads_rb, ir3_reads_k1, ir3_writes_ra,
                          ir3_is_load, ir3_is_stop};

    assign freeze   = !MemReady && ir3_is_mem;
    assign load_dst = IR2Out[7:6];
    // ori implicitly reads k1, so it collides only with a load into register 1.
    assign load_use = ir2_is_load &&
                      ((ir1_reads_ra && (IR1Out[7:6] == load_dst)) ||
                       (ir1_reads_rb && (IR1Out[5:4] == load_dst)) ||
                       (ir1_reads_k1 && (load_dst == 2'd1)));

    always_comb begin
        PCWrite    = 1'b0;
        IR1Load    = 1'b0;
        IR2Load    = 1'b0;
        IR3Load    = 1'b0;
        IR4Load    = 1'b0;
        IR1Flush   = 1'b0;
        IR2Flush   = 1'b0;
        Halted     = 1'b0;
        inc_stall  = 1'b0;
        inc_flush  = 1'b0;
        next_state = state;
        if (!reset) begin
            Halted = (state == ST_HALT);
            if (!freeze) begin
                case (state)
                    ST_HALT: begin
                        IR3Load = 1'b1;
                        IR4Load = 1'b1;
                    end
                    ST_STALL: begin
                        PCWrite    = 1'b1;
                        IR1Load    = 1'b1;
                        IR2Load    = 1'b1;
                        IR3Load    = 1'b1;
                        IR4Load    = 1'b1;
                        next_state = ST_RUN;
                    end
                    default: begin
                        IR3Load = 1'b1;
                        IR4Load = 1'b1;
                        IR2Load = 1'b1;
                        if (ir2_is_stop) begin
                            IR2Flush   = 1'b1;
                            next_state = ST_HALT;
                        end else if (BrTaken) begin
                            PCWrite   = 1'b1;
                            IR1Load   = 1'b1;
                            IR1Flush  = 1'b1;
                            IR2Flush  = 1'b1;
                            inc_flush = 1'b1;
                        end else if (load_use) begin
                            IR2Flush   = 1'b1;
                            inc_stall  = 1'b1;
                            next_state = ST_STALL;
                        end else begin
                            PCWrite = 1'b1;
                            IR1Load = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_RUN;
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            state <= next_state;
            if (inc_stall && (StallCount != '1))
                StallCount <= StallCount + CNT_ONE;
            if (inc_flush && (FlushCount != '1))
                FlushCount <= FlushCount + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed scenarios plus randomized traffic
// against a rule-level reference model; a CNT_W=2 instance covers saturation.
module tb_hazard_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] IR1Out, IR2Out, IR3Out;
    logic       BrTaken, MemReady;

    logic        pc_a, l1_a, l2_a, l3_a, l4_a, f1_a, f2_a, h_a;
    logic [15:0] sc_a, fc_a;
    logic        pc_b, l1_b, l2_b, l3_b, l4_b, f1_b, f2_b, h_b;
    logic [1:0]  sc_b, fc_b;
    logic [7:0]  obs_a, obs_b;

    int errors = 0;
    int checks = 0;

    // Reference model state: halted / bubble-pending flags and raw event counts.
    bit         m_halt, m_stall, n_halt, n_stall;
    int         m_stalls, m_flushes, n_stalls, n_flushes;
    logic [7:0] exp_out;

    hazard_sequencer #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset), .IR1Out(IR1Out), .IR2Out(IR2Out), .IR3Out(IR3Out),
        .BrTaken(BrTaken), .MemReady(MemReady), .PCWrite(pc_a), .IR1Load(l1_a),
        .IR2Load(l2_a), .IR3Load(l3_a), .IR4Load(l4_a), .IR1Flush(f1_a), .IR2Flush(f2_a),
        .Halted(h_a), .StallCount(sc_a), .FlushCount(fc_a)
    );

    hazard_sequencer #(.CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .IR1Out(IR1Out), .IR2Out(IR2Out), .IR3Out(IR3Out),
        .BrTaken(BrTaken), .MemReady(MemReady), .PCWrite(pc_b), .IR1Load(l1_b),
        .IR2Load(l2_b), .IR3Load(l3_b), .IR4Load(l4_b), .IR1Flush(f1_b), .IR2Flush(f2_b),
        .Halted(h_b), .StallCount(sc_b), .FlushCount(fc_b)
    );

    assign obs_a = {pc_a, l1_a, l2_a, l3_a, l4_a, f1_a, f2_a, h_a};
    assign obs_b = {pc_b, l1_b, l2_b, l3_b, l4_b, f1_b, f2_b, h_b};

    always #5 clock = ~clock;

    // Bitmap of architectural registers an instruction reads.
    function automatic logic [3:0] reads_mask(input logic [7:0] ir);
        logic [3:0] m;
        logic [3:0] op;
        m  = '0;
        op = ir[3:0];
        if (op == 4'h0) m[ir[5:4]] = 1'b1;
        else if (op == 4'h2 || op == 4'h4 || op == 4'h6 || op == 4'h8) begin
            m[ir[7:6]] = 1'b1;
            m[ir[5:4]] = 1'b1;
        end else if (op[2:0] == 3'b011) m[ir[7:6]] = 1'b1;
        else if (op[2:0] == 3'b111) m[1] = 1'b1;
        return m;
    endfunction

    function automatic int sat(input int v, input int w);
        int top;
        top = (1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    // Output vector order: PCWrite IR1Load IR2Load IR3Load IR4Load IR1Flush IR2Flush Halted
    task automatic drive(input bit r, input logic [7:0] i1, input logic [7:0] i2,
                         input logic [7:0] i3, input bit br, input bit mr);
        logic [3:0] rd;
        reset = r; IR1Out = i1; IR2Out = i2; IR3Out = i3; BrTaken = br; MemReady = mr;
        #1;
        n_halt = m_halt; n_stall = m_stall; n_stalls = m_stalls; n_flushes = m_flushes;
        rd = reads_mask(i1);
        if (r) begin
            exp_out = 8'b0000_0000;
            n_halt = 0; n_stall = 0; n_stalls = 0; n_flushes = 0;
        end else if (!mr && (i3[3:0] == 4'h0 || i3[3:0] == 4'h2)) begin
            exp_out = {7'b0, m_halt};
        end else if (m_halt) begin
            exp_out = 8'b0001_1001;
        end else if (m_stall) begin
            exp_out = 8'b1111_1000;
            n_stall = 0;
        end else if (i2[3:0] == 4'h1) begin
            exp_out = 8'b0011_1010;
            n_halt  = 1;
        end else if (br) begin
            exp_out = 8'b1111_1110;
            n_flushes++;
        end else if (i2[3:0] == 4'h0 && rd[i2[7:6]]) begin
            exp_out = 8'b0011_1010;
            n_stall = 1;
            n_stalls++;
        end else begin
            exp_out = 8'b1111_1000;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        m_halt = n_halt; m_stall = n_stall; m_stalls = n_stalls; m_flushes = n_flushes;
        #1;
    endtask

    task automatic do_reset();
        drive(1, 8'h0A, 8'h0A, 8'h0A, 0, 1);
        tick();
    endtask

    task automatic test_reset();
        drive(1, 8'h14, 8'h40, 8'h00, 1, 1);
        checks++;
        if (obs_a !== 8'b0000_0000) begin
            errors++; $display("FAIL reset_outputs got=%b exp=%b", obs_a, 8'b0);
        end
        tick();
        drive(0, 8'h0A, 8'h0A, 8'h0A, 0, 1);
        checks++;
        if (obs_a !== 8'b1111_1000) begin
            errors++; $display("FAIL reset_run_outputs got=%b exp=%b", obs_a, 8'b1111_1000);
        end
        checks++;
        if (sc_a !== 16'd0 || fc_a !== 16'd0) begin
            errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", sc_a, fc_a);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(0, 8'h14, 8'h40, 8'h0A, 0, 1);
        checks++;
        if (obs_a !== 8'b0011_1010) begin
            errors++; $display("FAIL load_use_bubble got=%b exp=%b", obs_a, 8'b0011_1010);
        end
        tick();
        drive(0, 8'h14, 8'h0A, 8'h40, 0, 1);
        checks++;
        if (obs_a !== 8'b1111_1000) begin
            errors++; $display("FAIL load_use_release got=%b exp=%b", obs_a, 8'b1111_1000);
        end
        checks++;
        if (sc_a !== 16'd1) begin
            errors++; $display("FAIL load_use_count got=%0d exp=1", sc_a);
        end
        // ori reads k1: collides with a load into r1
        tick();
        drive(0, 8'h07, 8'h40, 8'h0A, 0, 1);
        checks++;
        if (obs_a !== 8'b0011_1010) begin
            errors++; $display("FAIL load_use_ori got=%b exp=%b", obs_a, 8'b0011_1010);
        end
        tick();
    endtask

    task automatic test_no_dep();
        do_reset();
        drive(0, 8'h24, 8'h40, 8'h0A, 0, 1);
        checks++;
        if (obs_a !== 8'b1111_1000) begin
            errors++; $display("FAIL no_dep_outputs got=%b exp=%b", obs_a, 8'b1111_1000);
        end
        tick();
        drive(0, 8'h0A, 8'h0A, 8'h40, 0, 1);
        checks++;
        if (sc_a !== 16'd0) begin
            errors++; $display("FAIL no_dep_count got=%0d exp=0", sc_a);
        end
    endtask

    task automatic test_branch();
        do_reset();
        drive(0, 8'h14, 8'h05, 8'h0A, 1, 1);
        checks++;
        if (obs_a !== 8'b1111_1110) begin
            errors++; $display("FAIL branch_flush got=%b exp=%b", obs_a, 8'b1111_1110);
        end
        tick();
        drive(0, 8'h14, 8'h40, 8'h0A, 1, 1);
        checks++;
        if (fc_a !== 16'd1) begin
            errors++; $display("FAIL branch_count got=%0d exp=1", fc_a);
        end
        checks++;
        if (obs_a !== 8'b1111_1110) begin
            errors++; $display("FAIL branch_over_hazard got=%b exp=%b", obs_a, 8'b1111_1110);
        end
        tick();
        drive(0, 8'h0A, 8'h0A, 8'h0A, 0, 1);
        checks++;
        if (obs_a !== 8'b1111_1000 || sc_a !== 16'd0 || fc_a !== 16'd2) begin
            errors++;
            $display("FAIL branch_no_stall got=%b sc=%0d fc=%0d exp=%b sc=0 fc=2",
                     obs_a, sc_a, fc_a, 8'b1111_1000);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'h14, 8'h40, 8'h00, 1, 0);
            checks++;
            if (obs_a !== 8'b0000_0000) begin
                errors++; $display("FAIL mem_freeze_%0d got=%b exp=%b", i, obs_a, 8'b0);
            end
            tick();
        end
        drive(0, 8'h14, 8'h40, 8'h00, 0, 1);
        checks++;
        if (obs_a !== 8'b0011_1010 || sc_a !== 16'd0 || fc_a !== 16'd0) begin
            errors++;
            $display("FAIL mem_release got=%b sc=%0d fc=%0d exp=%b sc=0 fc=0",
                     obs_a, sc_a, fc_a, 8'b0011_1010);
        end
        tick();
        drive(0, 8'h14, 8'h0A, 8'h40, 0, 1);
        checks++;
        if (obs_a !== 8'b1111_1000 || sc_a !== 16'd1) begin
            errors++;
            $display("FAIL mem_stall_after got=%b sc=%0d exp=%b sc=1", obs_a, sc_a, 8'b1111_1000);
        end
        tick();
    endtask

    task automatic test_stop();
        do_reset();
        drive(0, 8'h0A, 8'h05, 8'h0A, 1, 1);
        tick();
        drive(0, 8'h01, 8'h01, 8'h0A, 0, 1);
        checks++;
        if (obs_a !== 8'b0011_1010) begin
            errors++; $display("FAIL stop_issue got=%b exp=%b", obs_a, 8'b0011_1010);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 8'h14, 8'h0A, 8'h01, 1, 1);
            checks++;
            if (obs_a !== 8'b0001_1001) begin
                errors++; $display("FAIL stop_drain_%0d got=%b exp=%b", i, obs_a, 8'b0001_1001);
            end
            tick();
        end
        drive(1, 8'h0A, 8'h0A, 8'h0A, 0, 1);
        checks++;
        if (obs_a !== 8'b0000_0000) begin
            errors++; $display("FAIL stop_reset got=%b exp=%b", obs_a, 8'b0);
        end
        tick();
        drive(0, 8'h0A, 8'h0A, 8'h0A, 0, 1);
        checks++;
        if (obs_a !== 8'b1111_1000 || fc_a !== 16'd0) begin
            errors++;
            $display("FAIL stop_resume got=%b fc=%0d exp=%b fc=0", obs_a, fc_a, 8'b1111_1000);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'h14, 8'h40, 8'h0A, 0, 1);
            tick();
            drive(0, 8'h0A, 8'h0A, 8'h40, 0, 1);
            tick();
        end
        drive(0, 8'h0A, 8'h0A, 8'h0A, 0, 1);
        checks++;
        if (sc_b !== 2'd3) begin
            errors++; $display("FAIL sat_stall_narrow got=%0d exp=3", sc_b);
        end
        checks++;
        if (sc_a !== 16'd5) begin
            errors++; $display("FAIL sat_stall_wide got=%0d exp=5", sc_a);
        end
    endtask

    task automatic test_random();
        logic [7:0] i1, i2, i3;
        bit         r, br, mr;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            i1 = 8'($urandom);
            i2 = 8'($urandom);
            i3 = 8'($urandom);
            if ($urandom_range(0, 2) == 0) i2[3:0] = 4'h0;
            if ($urandom_range(0, 3) == 0) i3[3:0] = 4'h2;
            r  = ($urandom_range(0, 15) == 0);
            br = ($urandom_range(0, 3) == 0);
            mr = ($urandom_range(0, 3) != 0);
            drive(r, i1, i2, i3, br, mr);
            checks++;
            if (obs_a !== exp_out || obs_b !== exp_out) begin
                errors++;
                $display("FAIL rand_outputs n=%0d got=%b/%b exp=%b", n, obs_a, obs_b, exp_out);
            end
            checks++;
            if (sc_a !== 16'(m_stalls) || fc_a !== 16'(m_flushes) ||
                sc_b !== 2'(sat(m_stalls, 2)) || fc_b !== 2'(sat(m_flushes, 2))) begin
                errors++;
                $display("FAIL rand_counts n=%0d got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d",
                         n, sc_a, fc_a, sc_b, fc_b, m_stalls, m_flushes,
                         sat(m_stalls, 2), sat(m_flushes, 2));
            end
            tick();
        end
    endtask

    initial begin
        m_halt = 0; m_stall = 0; m_stalls = 0; m_flushes = 0;
        test_reset();
        test_load_use();
        test_no_dep();
        test_branch();
        test_mem_wait();
        test_stop();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
